// File: rtl/rd_scoreboard_if.sv
// rd_scoreboard_if
//   Bundles the decode-side issue/query signals and the WB/kill retirement
//   signals of the pending-write scoreboard.
//   master : pipeline side (drives issue, source queries, retire, kill;
//            receives busy/stall/empty/err)
//   slave  : the scoreboard itself
interface rd_scoreboard_if #(
    parameter int IDX_W = 5
);
    logic             rd_scoreboard_issue_valid_i;
    logic             rd_scoreboard_issue_rd_en_i;
    logic [IDX_W-1:0] rd_scoreboard_issue_rd_index_i;
    logic             rd_scoreboard_rs1_en_i;
    logic [IDX_W-1:0] rd_scoreboard_rs1_index_i;
    logic             rd_scoreboard_rs2_en_i;
    logic [IDX_W-1:0] rd_scoreboard_rs2_index_i;
    logic             rd_scoreboard_wb_valid_i;
    logic [IDX_W-1:0] rd_scoreboard_wb_rd_index_i;
    logic             rd_scoreboard_kill_valid_i;
    logic [IDX_W-1:0] rd_scoreboard_kill_rd_index_i;
    logic             rd_scoreboard_rs1_busy_o;
    logic             rd_scoreboard_rs2_busy_o;
    logic             rd_scoreboard_stall_o;
    logic             rd_scoreboard_empty_o;
    logic             rd_scoreboard_err_o;

    modport master (
        output rd_scoreboard_issue_valid_i,
        output rd_scoreboard_issue_rd_en_i,
        output rd_scoreboard_issue_rd_index_i,
        output rd_scoreboard_rs1_en_i,
        output rd_scoreboard_rs1_index_i,
        output rd_scoreboard_rs2_en_i,
        output rd_scoreboard_rs2_index_i,
        output rd_scoreboard_wb_valid_i,
        output rd_scoreboard_wb_rd_index_i,
        output rd_scoreboard_kill_valid_i,
        output rd_scoreboard_kill_rd_index_i,
        input  rd_scoreboard_rs1_busy_o,
        input  rd_scoreboard_rs2_busy_o,
        input  rd_scoreboard_stall_o,
        input  rd_scoreboard_empty_o,
        input  rd_scoreboard_err_o
    );

    modport slave (
        input  rd_scoreboard_issue_valid_i,
        input  rd_scoreboard_issue_rd_en_i,
        input  rd_scoreboard_issue_rd_index_i,
        input  rd_scoreboard_rs1_en_i,
        input  rd_scoreboard_rs1_index_i,
        input  rd_scoreboard_rs2_en_i,
        input  rd_scoreboard_rs2_index_i,
        input  rd_scoreboard_wb_valid_i,
        input  rd_scoreboard_wb_rd_index_i,
        input  rd_scoreboard_kill_valid_i,
        input  rd_scoreboard_kill_rd_index_i,
        output rd_scoreboard_rs1_busy_o,
        output rd_scoreboard_rs2_busy_o,
        output rd_scoreboard_stall_o,
        output rd_scoreboard_empty_o,
        output rd_scoreboard_err_o
    );
endinterface

// File: rtl/rd_scoreboard.sv
// rd_scoreboard
//   Per-register pending-write tracker for the decode stage. Counts rd writes
//   issued out of ID that have not yet retired in WB (or been squashed),
//   reports busy source operands, stalls ID when a counter would overflow,
//   and reports when no writes are pending anywhere.
// Ports:
//   clk  - core clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, wins over same-cycle events
//   sb   - rd_scoreboard_if.slave: issue, rs1/rs2 query, WB retire, kill
//          inputs; rs1/rs2 busy, stall, empty, sticky underflow err outputs
module rd_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 2,
    parameter int TOT_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    rd_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef struct packed {
        logic [CNT_W-1:0] val;
        logic             uf;
        logic [1:0]       applied;   // decrements actually taken
    } cnt_step_t;

    typedef struct packed {
        logic [TOT_W-1:0] val;
        logic             uf;
    } tot_step_t;

    // Apply +inc -dec to a per-register count. A decrement that would go
    // below zero is dropped (count clamps at 0) and reported as underflow.
    function automatic cnt_step_t cnt_step(input logic [CNT_W-1:0] c,
                                           input logic             inc,
                                           input logic [1:0]       dec);
        logic signed [CNT_W+2:0] sum;
        cnt_step_t               res;
        sum = $signed({3'b000, c}) + $signed({{(CNT_W+2){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec});
        res = '0;
        if (sum < 0) begin
            res.val     = '0;
            res.uf      = 1'b1;
            res.applied = 2'(32'(c) + 32'(inc));
        end else if (sum > $signed({3'b000, CNT_MAX})) begin
            res.val     = CNT_MAX;
            res.applied = dec;
        end else begin
            res.val     = CNT_W'(sum);
            res.applied = dec;
        end
        return res;
    endfunction

    // Same clamp/saturate rule for the total count.
    function automatic tot_step_t tot_step(input logic [TOT_W-1:0] t,
                                           input logic             inc,
                                           input logic [1:0]       dec);
        logic signed [TOT_W+2:0] sum;
        tot_step_t               res;
        sum = $signed({3'b000, t}) + $signed({{(TOT_W+2){1'b0}}, inc})
            - $signed({{(TOT_W+1){1'b0}}, dec});
        res = '0;
        if (sum < 0) begin
            res.val = '0;
            res.uf  = 1'b1;
        end else if (sum > $signed({3'b000, TOT_MAX})) begin
            res.val = TOT_MAX;
        end else begin
            res.val = TOT_W'(sum);
        end
        return res;
    endfunction

    logic [CNT_W-1:0] cnt [REG_NUM];
    logic [TOT_W-1:0] tot;
    logic             err;

    // x0 (and any index beyond REG_NUM) never has a pending write.
    function automatic logic [CNT_W-1:0] cnt_at(input logic [IDX_W-1:0] idx);
        if (idx == '0 || int'(idx) >= REG_NUM) begin
            return '0;
        end
        return cnt[idx];
    endfunction

    logic       issue_req;
    logic       issue_fire;
    logic       retire_hit;
    logic       kill_hit;
    logic       rd_same_dec;
    logic       stall;
    cnt_step_t  step [REG_NUM];
    tot_step_t  tot_res;
    logic [1:0] dec_applied;
    logic       cnt_uf;

    assign issue_req  = sb.rd_scoreboard_issue_valid_i & sb.rd_scoreboard_issue_rd_en_i
                      & (sb.rd_scoreboard_issue_rd_index_i != '0);
    assign retire_hit = sb.rd_scoreboard_wb_valid_i & (sb.rd_scoreboard_wb_rd_index_i != '0);
    assign kill_hit   = sb.rd_scoreboard_kill_valid_i & (sb.rd_scoreboard_kill_rd_index_i != '0);

    // A same-cycle retire/kill of the issuing rd frees a slot, so a full
    // counter can still accept the issue with a net delta of zero.
    assign rd_same_dec = (retire_hit & (sb.rd_scoreboard_wb_rd_index_i == sb.rd_scoreboard_issue_rd_index_i))
                       | (kill_hit & (sb.rd_scoreboard_kill_rd_index_i == sb.rd_scoreboard_issue_rd_index_i));

    assign stall = sb.rd_scoreboard_issue_valid_i
                 & ((sb.rd_scoreboard_issue_rd_en_i & (sb.rd_scoreboard_issue_rd_index_i != '0)
                     & (cnt_at(sb.rd_scoreboard_issue_rd_index_i) == CNT_MAX) & ~rd_same_dec)
                    | ((tot == TOT_MAX) & ~(retire_hit | kill_hit)));

    assign issue_fire = issue_req & ~stall;

    always_comb begin
        dec_applied = '0;
        cnt_uf      = 1'b0;
        for (int r = 0; r < REG_NUM; r++) begin
            if (r == 0) begin
                step[r] = '0;
            end else begin
                step[r] = cnt_step(cnt[r],
                                   issue_fire && (int'(sb.rd_scoreboard_issue_rd_index_i) == r),
                                   {1'b0, retire_hit && (int'(sb.rd_scoreboard_wb_rd_index_i) == r)}
                                 + {1'b0, kill_hit && (int'(sb.rd_scoreboard_kill_rd_index_i) == r)});
            end
            dec_applied = dec_applied + step[r].applied;
            cnt_uf      = cnt_uf | step[r].uf;
        end
        // Only decrements that a register counter actually took reduce tot,
        // so tot stays equal to the sum of the per-register counts.
        tot_res = tot_step(tot, issue_fire, dec_applied);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt[r] <= '0;
            end
            tot <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt[r] <= step[r].val;
            end
            tot <= tot_res.val;
            if (cnt_uf | tot_res.uf) begin
                err <= 1'b1;
            end
        end
    end

    // Busy uses registered counts only: a same-cycle retire is covered by
    // the forwarding network, so it must still read as busy here.
    assign sb.rd_scoreboard_rs1_busy_o = sb.rd_scoreboard_rs1_en_i
                                       & (cnt_at(sb.rd_scoreboard_rs1_index_i) != '0);
    assign sb.rd_scoreboard_rs2_busy_o = sb.rd_scoreboard_rs2_en_i
                                       & (cnt_at(sb.rd_scoreboard_rs2_index_i) != '0);
    assign sb.rd_scoreboard_stall_o    = stall;
    assign sb.rd_scoreboard_empty_o    = (tot == '0);
    assign sb.rd_scoreboard_err_o      = err;

endmodule

// File: tb/tb_rd_scoreboard.sv
module tb_rd_scoreboard;

    logic clk;
    logic rst;
    logic chk_vld;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [4:0] exp;   // {rs1_busy, rs2_busy, stall, empty, err}
    } exp_t;

    exp_t exp_q[$];

    rd_scoreboard_if #(.IDX_W(5)) sb_if ();

    rd_scoreboard #(
        .REG_NUM(32),
        .IDX_W  (5),
        .CNT_W  (2),
        .TOT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // One cycle of stimulus, driven just after the rising edge. When chk is
    // set, the expected outputs for this cycle are queued for the monitor.
    task automatic step(input string name,
                        input logic iv, input logic ien, input logic [4:0] iidx,
                        input logic r1e, input logic [4:0] r1i,
                        input logic r2e, input logic [4:0] r2i,
                        input logic wv, input logic [4:0] widx,
                        input logic kv, input logic [4:0] kidx,
                        input logic chk, input logic [4:0] expv);
        exp_t e;
        sb_if.rd_scoreboard_issue_valid_i    = iv;
        sb_if.rd_scoreboard_issue_rd_en_i    = ien;
        sb_if.rd_scoreboard_issue_rd_index_i = iidx;
        sb_if.rd_scoreboard_rs1_en_i         = r1e;
        sb_if.rd_scoreboard_rs1_index_i      = r1i;
        sb_if.rd_scoreboard_rs2_en_i         = r2e;
        sb_if.rd_scoreboard_rs2_index_i      = r2i;
        sb_if.rd_scoreboard_wb_valid_i       = wv;
        sb_if.rd_scoreboard_wb_rd_index_i    = widx;
        sb_if.rd_scoreboard_kill_valid_i     = kv;
        sb_if.rd_scoreboard_kill_rd_index_i  = kidx;
        chk_vld = chk;
        if (chk) begin
            e.name = name;
            e.exp  = expv;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge and checks against the queue.
    initial begin
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                got = {sb_if.rd_scoreboard_rs1_busy_o, sb_if.rd_scoreboard_rs2_busy_o,
                       sb_if.rd_scoreboard_stall_o, sb_if.rd_scoreboard_empty_o,
                       sb_if.rd_scoreboard_err_o};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got {b1,b2,stall,empty,err}=%b, no expectation queued", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.exp) begin
                        errors++;
                        $display("FAIL %s: got {b1,b2,stall,empty,err}=%b expected %b",
                                 e.name, got, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        chk_vld = 1'b0;
        rst     = 1'b1;
        sb_if.rd_scoreboard_issue_valid_i    = 1'b0;
        sb_if.rd_scoreboard_issue_rd_en_i    = 1'b0;
        sb_if.rd_scoreboard_issue_rd_index_i = '0;
        sb_if.rd_scoreboard_rs1_en_i         = 1'b0;
        sb_if.rd_scoreboard_rs1_index_i      = '0;
        sb_if.rd_scoreboard_rs2_en_i         = 1'b0;
        sb_if.rd_scoreboard_rs2_index_i      = '0;
        sb_if.rd_scoreboard_wb_valid_i       = 1'b0;
        sb_if.rd_scoreboard_wb_rd_index_i    = '0;
        sb_if.rd_scoreboard_kill_valid_i     = 1'b0;
        sb_if.rd_scoreboard_kill_rd_index_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        //    name           iv ien idx  r1e r1i  r2e r2i  wv widx kv kidx chk exp{b1,b2,st,em,er}
        step("rst_state",    0, 0,  0,   1,  5,   1,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss_x5",       1, 1,  5,   1,  5,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("busy_x5",      0, 0,  0,   1,  5,   0,  0,   0, 0,   0, 0,   1, 5'b10000);
        step("ret_x5",       0, 0,  0,   1,  5,   0,  0,   1, 5,   0, 0,   1, 5'b10000);
        step("clr_x5",       0, 0,  0,   1,  5,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss_x0",       1, 1,  0,   0,  0,   1,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("after_x0",     0, 0,  0,   1,  0,   1,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss7a",        1, 1,  7,   1,  7,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss7b",        1, 1,  7,   1,  7,   1,  7,   0, 0,   0, 0,   1, 5'b11000);
        step("iss7c",        1, 1,  7,   1,  7,   0,  0,   0, 0,   0, 0,   1, 5'b10000);
        step("req4_stall",   1, 1,  7,   1,  7,   0,  0,   0, 0,   0, 0,   1, 5'b10100);
        step("req4_ret",     1, 1,  7,   1,  7,   0,  0,   1, 7,   0, 0,   1, 5'b10000);
        step("req4_again",   1, 1,  7,   0,  0,   1,  7,   0, 0,   0, 0,   1, 5'b01100);
        step("drain7_1",     0, 0,  0,   1,  7,   0,  0,   1, 7,   0, 0,   1, 5'b10000);
        step("drain7_2",     0, 0,  0,   1,  7,   0,  0,   1, 7,   0, 0,   1, 5'b10000);
        step("drain7_3",     0, 0,  0,   1,  7,   0,  0,   1, 7,   0, 0,   1, 5'b10000);
        step("x7_clr",       0, 0,  0,   1,  7,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss9",         1, 1,  9,   1,  9,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("tri9",         1, 1,  9,   1,  9,   0,  0,   1, 9,   1, 9,   1, 5'b10000);
        step("net9",         0, 0,  0,   1,  9,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss15",        1, 1,  15,  1,  15,  0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("kill15",       0, 0,  0,   1,  15,  0,  0,   0, 0,   1, 15,  1, 5'b10000);
        step("after_kill15", 0, 0,  0,   1,  15,  0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("iss20",        1, 1,  20,  0,  0,   0,  0,   0, 0,   0, 0,   1, 5'b00010);
        step("ret12_uf",     0, 0,  0,   1,  12,  0,  0,   1, 12,  0, 0,   1, 5'b00000);
        step("err_set",      0, 0,  0,   1,  12,  1,  20,  0, 0,   0, 0,   1, 5'b01001);
        step("ret20",        0, 0,  0,   0,  0,   1,  20,  1, 20,  0, 0,   1, 5'b01001);
        step("err_sticky",   0, 0,  0,   1,  12,  0,  0,   0, 0,   0, 0,   1, 5'b00011);
        step("iss3",         1, 1,  3,   0,  0,   0,  0,   0, 0,   0, 0,   1, 5'b00011);
        step("iss4",         1, 1,  4,   1,  3,   0,  0,   0, 0,   0, 0,   1, 5'b10001);
        rst = 1'b1;
        step("rst_mid",      0, 0,  0,   1,  3,   1,  4,   1, 3,   0, 0,   1, 5'b11001);
        rst = 1'b0;
        step("post_rst",     0, 0,  0,   1,  3,   1,  4,   0, 0,   0, 0,   1, 5'b00010);
        step("post_rst2",    0, 0,  0,   1,  4,   1,  3,   0, 0,   0, 0,   1, 5'b00010);
        step("idle",         0, 0,  0,   0,  0,   0,  0,   0, 0,   0, 0,   0, 5'b00000);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
